// File: rtl/shiftreg_sequencer_if.sv
// Frame request handshake plus generator-side drive lines of the shift-register sequencer.
// The master modport is the sequencer; the slave modport is the requesting control logic.
interface shiftreg_sequencer_if #(
  parameter int SIZESRDYN  = 16,
  parameter int SIZESRSTAT = 88,
  parameter int CNTW       = 8
);
  logic                  start_valid;
  logic                  start_ready;
  logic [SIZESRDYN-1:0]  dyn_word;
  logic [SIZESRSTAT-1:0] stat_word;
  logic                  SELDYN;
  logic                  SELSTAT;
  logic                  signal_out;
  logic                  busy;
  logic                  done;
  logic [CNTW-1:0]       frame_cnt;

  modport master (
    input  start_valid, dyn_word, stat_word,
    output start_ready, SELDYN, SELSTAT, signal_out, busy, done, frame_cnt
  );

  modport slave (
    output start_valid, dyn_word, stat_word,
    input  start_ready, SELDYN, SELSTAT, signal_out, busy, done, frame_cnt
  );
endinterface

// File: rtl/shiftreg_sequencer.sv
// Serialises one dynamic + one static word per handshake into the shift-register generator,
// MSB first, then pulses the commit select so both latches in the generator are loaded.
module shiftreg_sequencer #(
  parameter int SIZESRDYN  = 16,
  parameter int SIZESRSTAT = 88,
  parameter int CNTW       = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  shiftreg_sequencer_if.master   sq
);
  localparam int MAXLEN = (SIZESRDYN > SIZESRSTAT) ? SIZESRDYN : SIZESRSTAT;
  localparam int CW     = (MAXLEN > 2) ? $clog2(MAXLEN) : 1;
  localparam logic [CW-1:0] DYN_LAST  = CW'(SIZESRDYN - 1);
  localparam logic [CW-1:0] STAT_LAST = CW'(SIZESRSTAT - 1);

  typedef enum logic [2:0] {IDLE, SHIFT_DYN, SHIFT_STAT, COMMIT, DONE} state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         cnt, cnt_nx;
  logic                  accept;
  logic                  sel_dyn_nx, sel_stat_nx, sig_nx, busy_nx, done_nx, ready_nx;
  logic [SIZESRDYN-1:0]  dyn_sh;
  logic [SIZESRSTAT-1:0] stat_sh;

  assign accept = sq.start_valid && sq.start_ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Bit counter restarts from zero on every state entry.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = SHIFT_DYN;
          cnt_nx   = '0;
        end
      end
      SHIFT_DYN: begin
        if (cnt == DYN_LAST) begin
          state_nx = SHIFT_STAT;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      SHIFT_STAT: begin
        if (cnt == STAT_LAST) begin
          state_nx = COMMIT;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      COMMIT: begin
        state_nx = DONE;
        cnt_nx   = '0;
      end
      DONE: begin
        state_nx = accept ? SHIFT_DYN : IDLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with it.
  always_comb begin
    sel_dyn_nx  = (state_nx == SHIFT_DYN) || (state_nx == COMMIT);
    sel_stat_nx = (state_nx == SHIFT_STAT);
    busy_nx     = (state_nx == SHIFT_DYN) || (state_nx == SHIFT_STAT) || (state_nx == COMMIT);
    done_nx     = (state_nx == DONE);
    ready_nx    = (state_nx == IDLE) || (state_nx == DONE);
    sig_nx      = 1'b0;
    case (state_nx)
      SHIFT_DYN:  sig_nx = (state == SHIFT_DYN)  ? dyn_sh[SIZESRDYN-2]   : sq.dyn_word[SIZESRDYN-1];
      SHIFT_STAT: sig_nx = (state == SHIFT_STAT) ? stat_sh[SIZESRSTAT-2] : stat_sh[SIZESRSTAT-1];
      default:    sig_nx = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sq.start_ready <= 1'b0;
      sq.SELDYN      <= 1'b0;
      sq.SELSTAT     <= 1'b0;
      sq.signal_out  <= 1'b0;
      sq.busy        <= 1'b0;
      sq.done        <= 1'b0;
      sq.frame_cnt   <= '0;
    end else begin
      sq.start_ready <= ready_nx;
      sq.SELDYN      <= sel_dyn_nx;
      sq.SELSTAT     <= sel_stat_nx;
      sq.signal_out  <= sig_nx;
      sq.busy        <= busy_nx;
      sq.done        <= done_nx;
      if (done_nx) sq.frame_cnt <= sq.frame_cnt + CNTW'(1);
    end
  end

  // Shadow words: the MSB already went out on entry, so each further shift exposes the next bit.
  always_ff @(posedge CLK) begin
    if (accept) begin
      dyn_sh  <= sq.dyn_word;
      stat_sh <= sq.stat_word;
    end else begin
      if (state == SHIFT_DYN && state_nx == SHIFT_DYN)
        dyn_sh <= {dyn_sh[SIZESRDYN-2:0], 1'b0};
      if (state == SHIFT_STAT && state_nx == SHIFT_STAT)
        stat_sh <= {stat_sh[SIZESRSTAT-2:0], 1'b0};
    end
  end
endmodule

// File: tb/tb_shiftreg_sequencer.sv
// Directed bench for shiftreg_sequencer: frame timing, bit order, handshake, reset and
// counter wrap, with a behavioural generator model closing the loop on the latched words.
module tb_shiftreg_sequencer;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  shiftreg_sequencer_if #(.SIZESRDYN(16), .SIZESRSTAT(88), .CNTW(8)) bus ();
  shiftreg_sequencer #(.SIZESRDYN(16), .SIZESRSTAT(88), .CNTW(8)) dut (
    .CLK(CLK), .RST(RST), .sq(bus)
  );

  shiftreg_sequencer_if #(.SIZESRDYN(2), .SIZESRSTAT(3), .CNTW(2)) sbus ();
  shiftreg_sequencer #(.SIZESRDYN(2), .SIZESRSTAT(3), .CNTW(2)) u_small (
    .CLK(CLK), .RST(RST), .sq(sbus)
  );

  int checks = 0;
  int passed = 0;

  // Behavioural generator: shifts under each select, latches on select hand-over.
  logic [15:0] g_dyn_sr, g_dynlatch;
  logic [87:0] g_stat_sr, g_statlatch;
  logic        g_prev_sd = 1'b0, g_prev_ss = 1'b0;
  always @(posedge CLK) begin
    g_prev_sd <= bus.SELDYN;
    g_prev_ss <= bus.SELSTAT;
    if (bus.SELDYN)  g_dyn_sr  <= {g_dyn_sr[14:0], bus.signal_out};
    if (bus.SELSTAT) g_stat_sr <= {g_stat_sr[86:0], bus.signal_out};
    if (bus.SELSTAT && g_prev_sd) g_dynlatch  <= g_dyn_sr;
    if (bus.SELDYN  && g_prev_ss) g_statlatch <= g_stat_sr;
  end

  logic       sd [1:106];
  logic       ss [1:106];
  logic       so [1:106];
  logic       bz [1:106];
  logic       dn [1:106];
  logic       rd [1:106];
  logic [7:0] fc [1:106];

  task automatic start_frame(input logic [15:0] d, input logic [87:0] s, input bit hold);
    int n = 0;
    while (bus.start_ready !== 1'b1 && n < 300) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (bus.start_ready !== 1'b1) $display("FAIL start_ready_wait: got %b expected 1", bus.start_ready);
    else passed++;
    bus.dyn_word    = d;
    bus.stat_word   = s;
    bus.start_valid = 1'b1;
    @(negedge CLK);
    if (!hold) begin
      bus.start_valid = 1'b0;
      bus.dyn_word    = ~d;
      bus.stat_word   = ~s;
    end
  endtask

  // Caller sits at the negedge of cycle 1 of a frame; returns at the negedge of cycle 106.
  task automatic capture(input int inject_at);
    for (int c = 1; c <= 106; c++) begin
      if (c > 1) @(negedge CLK);
      if (inject_at > 0 && c == inject_at) begin
        bus.start_valid = 1'b1;
        bus.dyn_word    = 16'h5A5A;
        bus.stat_word   = 88'hA5A5A5A5A5A5A5A5A5A5A5;
      end
      if (inject_at > 0 && c == inject_at + 3) bus.start_valid = 1'b0;
      sd[c] = bus.SELDYN;
      ss[c] = bus.SELSTAT;
      so[c] = bus.signal_out;
      bz[c] = bus.busy;
      dn[c] = bus.done;
      rd[c] = bus.start_ready;
      fc[c] = bus.frame_cnt;
    end
  endtask

  task automatic check_frame(input logic [15:0] d, input logic [87:0] s, input logic [7:0] cnt_exp,
                             input string tag);
    int sel_err = 0, bsy_err = 0, rdy_err = 0, dn_err = 0;
    logic [15:0] gd = '0;
    logic [87:0] gs = '0;
    logic esd, ess;
    for (int c = 1; c <= 106; c++) begin
      if (c <= 16)       begin esd = 1'b1; ess = 1'b0; end
      else if (c <= 104) begin esd = 1'b0; ess = 1'b1; end
      else if (c == 105) begin esd = 1'b1; ess = 1'b0; end
      else               begin esd = 1'b0; ess = 1'b0; end
      if (sd[c] !== esd || ss[c] !== ess) sel_err++;
      if (c == 105 && so[c] !== 1'b0) sel_err++;
      if (bz[c] !== (c <= 105)) bsy_err++;
      if (rd[c] !== (c == 106)) rdy_err++;
      if (dn[c] !== (c == 106)) dn_err++;
      if (c <= 16) gd[16-c] = so[c];
      else if (c <= 104) gs[104-c] = so[c];
    end
    checks++;
    if (sel_err != 0) $display("FAIL %s sel_pattern: got %0d bad cycles expected 0", tag, sel_err);
    else passed++;
    checks++;
    if (gd !== d) $display("FAIL %s dyn_bits: got %h expected %h", tag, gd, d);
    else passed++;
    checks++;
    if (gs !== s) $display("FAIL %s stat_bits: got %h expected %h", tag, gs, s);
    else passed++;
    checks++;
    if (bsy_err != 0) $display("FAIL %s busy_pattern: got %0d bad cycles expected 0", tag, bsy_err);
    else passed++;
    checks++;
    if (rdy_err != 0) $display("FAIL %s ready_pattern: got %0d bad cycles expected 0", tag, rdy_err);
    else passed++;
    checks++;
    if (dn_err != 0) $display("FAIL %s done_pattern: got %0d bad cycles expected 0", tag, dn_err);
    else passed++;
    checks++;
    if (fc[106] !== cnt_exp) $display("FAIL %s frame_cnt: got %0d expected %0d", tag, fc[106], cnt_exp);
    else passed++;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if (bus.start_ready !== 1'b0) $display("FAIL rst_ready: got %b expected 0", bus.start_ready);
    else passed++;
    checks++;
    if ({bus.SELDYN, bus.SELSTAT, bus.signal_out} !== 3'b000)
      $display("FAIL rst_sel_sig: got %b expected 000", {bus.SELDYN, bus.SELSTAT, bus.signal_out});
    else passed++;
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) $display("FAIL rst_busy_done: got %b expected 00", {bus.busy, bus.done});
    else passed++;
    checks++;
    if (bus.frame_cnt !== 8'd0) $display("FAIL rst_frame_cnt: got %0d expected 0", bus.frame_cnt);
    else passed++;
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.start_ready !== 1'b1) $display("FAIL rst_release_ready: got %b expected 1", bus.start_ready);
    else passed++;
    checks++;
    if (sbus.start_ready !== 1'b1 || sbus.frame_cnt !== 2'd0)
      $display("FAIL small_rst: got ready=%b cnt=%0d expected ready=1 cnt=0", sbus.start_ready, sbus.frame_cnt);
    else passed++;
  endtask

  task automatic test_reset_midframe;
    int bad = 0;
    start_frame(16'hFFFF, {88{1'b1}}, 1'b0);
    repeat (49) @(negedge CLK);
    checks++;
    if (bus.SELSTAT !== 1'b1) $display("FAIL mid_pre_selstat: got %b expected 1", bus.SELSTAT);
    else passed++;
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if ({bus.SELDYN, bus.SELSTAT, bus.busy, bus.start_ready, bus.done, bus.signal_out} !== 6'b0)
      $display("FAIL mid_rst_outputs: got %b expected 000000",
               {bus.SELDYN, bus.SELSTAT, bus.busy, bus.start_ready, bus.done, bus.signal_out});
    else passed++;
    checks++;
    if (bus.frame_cnt !== 8'd0) $display("FAIL mid_rst_cnt: got %0d expected 0", bus.frame_cnt);
    else passed++;
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.start_ready !== 1'b1) $display("FAIL mid_release_ready: got %b expected 1", bus.start_ready);
    else passed++;
    for (int i = 0; i < 120; i++) begin
      @(negedge CLK);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL mid_dropped_frame: got %0d active cycles expected 0", bad);
    else passed++;
    checks++;
    if (bus.frame_cnt !== 8'd0) $display("FAIL mid_cnt_after: got %0d expected 0", bus.frame_cnt);
    else passed++;
  endtask

  task automatic test_single_frame;
    start_frame(16'hABCD, 88'h123456789ABCDEF1234567, 1'b0);
    capture(0);
    check_frame(16'hABCD, 88'h123456789ABCDEF1234567, 8'd1, "single");
    @(negedge CLK);
    checks++;
    if ({bus.done, bus.start_ready, bus.busy} !== 3'b010)
      $display("FAIL single_after_done: got %b expected 010", {bus.done, bus.start_ready, bus.busy});
    else passed++;
  endtask

  task automatic test_closed_loop;
    start_frame(16'h0001, {88{1'b1}}, 1'b0);
    capture(0);
    check_frame(16'h0001, {88{1'b1}}, 8'd2, "loop1");
    checks++;
    if (g_dynlatch !== 16'h0001) $display("FAIL loop1_dynlatch: got %h expected 0001", g_dynlatch);
    else passed++;
    checks++;
    if (g_statlatch !== {88{1'b1}}) $display("FAIL loop1_statlatch: got %h expected all ones", g_statlatch);
    else passed++;
    @(negedge CLK);
    start_frame(16'h8000, 88'h0, 1'b0);
    capture(0);
    check_frame(16'h8000, 88'h0, 8'd3, "loop2");
    checks++;
    if (g_dynlatch !== 16'h8000) $display("FAIL loop2_dynlatch: got %h expected 8000", g_dynlatch);
    else passed++;
    checks++;
    if (g_statlatch !== 88'h0) $display("FAIL loop2_statlatch: got %h expected 0", g_statlatch);
    else passed++;
  endtask

  task automatic test_busy_ignore;
    start_frame(16'h3C5A, 88'hF0E1D2C3B4A5968778695A, 1'b0);
    capture(50);
    check_frame(16'h3C5A, 88'hF0E1D2C3B4A5968778695A, 8'd4, "busy_ignore");
  endtask

  task automatic test_back_to_back;
    logic [15:0] wd [0:2];
    logic [87:0] ws [0:2];
    wd[0] = 16'h1234; ws[0] = 88'h0102030405060708090A0B;
    wd[1] = 16'hFEDC; ws[1] = 88'hFFEEDDCCBBAA9988776655;
    wd[2] = 16'h0F0F; ws[2] = 88'h8000000000000000000001;
    start_frame(wd[0], ws[0], 1'b1);
    for (int f = 0; f < 3; f++) begin
      capture(0);
      if (f < 2) begin
        bus.dyn_word  = wd[f+1];
        bus.stat_word = ws[f+1];
      end else begin
        bus.start_valid = 1'b0;
      end
      check_frame(wd[f], ws[f], 8'(5 + f), $sformatf("b2b%0d", f));
      if (f < 2) @(negedge CLK);
    end
    @(negedge CLK);
    checks++;
    if (bus.busy !== 1'b0 || bus.frame_cnt !== 8'd7)
      $display("FAIL b2b_end: got busy=%b cnt=%0d expected busy=0 cnt=7", bus.busy, bus.frame_cnt);
    else passed++;
  endtask

  task automatic test_counter_wrap;
    logic [1:0] exp_cnt [0:4];
    logic [1:0] got_cnt [0:4];
    int         at [0:4];
    int         found = 0, per_err = 0, cnt_err = 0;
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd0; exp_cnt[4] = 2'd1;
    sbus.dyn_word    = 2'b10;
    sbus.stat_word   = 3'b101;
    sbus.start_valid = 1'b1;
    for (int t = 0; t < 100 && found < 5; t++) begin
      @(negedge CLK);
      if (sbus.done === 1'b1) begin
        got_cnt[found] = sbus.frame_cnt;
        at[found]      = t;
        found++;
      end
    end
    sbus.start_valid = 1'b0;
    checks++;
    if (found != 5) $display("FAIL wrap_done_count: got %0d expected 5", found);
    else passed++;
    for (int i = 0; i < found; i++) begin
      if (got_cnt[i] !== exp_cnt[i]) cnt_err++;
      if (i > 0 && at[i] - at[i-1] != 7) per_err++;
    end
    checks++;
    if (cnt_err != 0 || found != 5) $display("FAIL wrap_sequence: got %0d bad values expected 0", cnt_err);
    else passed++;
    checks++;
    if (per_err != 0) $display("FAIL wrap_period: got %0d bad intervals expected 0", per_err);
    else passed++;
  endtask

  initial begin
    bus.start_valid  = 1'b0;
    bus.dyn_word     = '0;
    bus.stat_word    = '0;
    sbus.start_valid = 1'b0;
    sbus.dyn_word    = '0;
    sbus.stat_word   = '0;
    RST = 1'b1;
    test_reset;
    test_reset_midframe;
    test_single_frame;
    test_closed_loop;
    test_busy_ignore;
    test_back_to_back;
    test_counter_wrap;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
